// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit with a fixed memory read latency.
// Optional misaligned-redirect trap: define FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
  parameter logic [31:0] START_PC     = 32'h8002_0000,
  parameter int          READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        insn_ready,
  output logic        insn_valid,
  output logic [31:0] insn_out,
  output logic [31:0] pc_out,
  output logic        fault,
  output logic        mem_enable,
  output logic        mem_rd_wr,
  output logic [1:0]  mem_access_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  input  logic        mem_busy,
  input  logic [31:0] mem_data_out
);

  typedef enum logic [1:0] {ISSUE, WAIT, HOLD, HALT} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [31:0] pc;
  logic        pend;
  logic [31:0] pend_pc;
  logic        misal;
  logic [31:0] tgt;

  // mem_busy carries no sequencing meaning; the latency counter alone times reads.
  logic unused_ok;
  assign unused_ok = &{1'b0, mem_busy, redirect_pc[1:0]};

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q;
  assign misal = redirect && (redirect_pc[1:0] != 2'b00);
  assign tgt   = redirect_pc;
  assign fault = fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      fault_q <= 1'b0;
    else if (state != HALT && misal) fault_q <= 1'b1;
  end
`else
  assign misal = 1'b0;
  assign tgt   = {redirect_pc[31:2], 2'b00};
  assign fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ISSUE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ISSUE: if (misal)                  state_nxt = HALT;
             else if (redirect)          state_nxt = ISSUE;
             else                        state_nxt = WAIT;
      WAIT:  if (misal)                  state_nxt = HALT;
             else if (cnt == 4'd0)       state_nxt = (pend || redirect) ? ISSUE : HOLD;
      HOLD:  if (misal)                  state_nxt = HALT;
             else if (redirect || insn_ready) state_nxt = ISSUE;
      HALT:                              state_nxt = HALT;
      default:                           state_nxt = ISSUE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= START_PC;
      cnt        <= 4'd0;
      pend       <= 1'b0;
      pend_pc    <= 32'd0;
      insn_valid <= 1'b0;
      insn_out   <= 32'd0;
      pc_out     <= 32'd0;
    end else if (misal) begin
      pend       <= 1'b0;
      insn_valid <= 1'b0;
    end else begin
      case (state)
        ISSUE: begin
          if (redirect) pc  <= tgt;
          else          cnt <= 4'(READ_LATENCY - 1);
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
            if (redirect) begin
              pend    <= 1'b1;
              pend_pc <= tgt;
            end
          end else begin
            // Read data lands on this edge; a redirect seen during the wait drops it.
            pend <= 1'b0;
            if (redirect)  pc <= tgt;
            else if (pend) pc <= pend_pc;
            else begin
              insn_valid <= 1'b1;
              insn_out   <= mem_data_out;
              pc_out     <= pc;
              pc         <= pc + 32'd4;
            end
          end
        end
        HOLD: begin
          if (redirect) begin
            pc         <= tgt;
            insn_valid <= 1'b0;
          end else if (insn_ready) begin
            insn_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_enable      = 1'b0;
    mem_rd_wr       = 1'b0;
    mem_access_size = 2'b00;
    mem_addr        = pc;
    mem_data_in     = 32'd0;
    if (rst_n && state == ISSUE) begin
      mem_enable = 1'b1;
      mem_rd_wr  = 1'b1;
    end
  end

endmodule
